// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Serial bit-stream transmitter. It drives the 1-bit serial input of the
//   sequence-detector FSMs from a parallel word. On an accepted start, the
//   word is shifted out MSB first, one bit per clock. GAP idle-zero cycles
//   follow the frame, and then done pulses for one cycle.
//
//   Optional feature macro: SERIAL_PARITY_EN
//     When defined, one even-parity bit (the XOR of the captured word) is
//     sent after the LSB with valid=1. The frame is then WIDTH+1 bits long.
//
// Parameters
//   WIDTH  bits per frame (>=2)
//   GAP    idle cycles with x=0 after the last frame bit (>=0)
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      request to load data and transmit
//   data       in   WIDTH  word to send, captured on the accepting edge only
//   x          out  1      serial data out, registered
//   valid      out  1      high while x carries a frame bit
//   busy       out  1      high from the cycle after accept until done falls
//   done       out  1      one-cycle pulse at the end of the frame
//   state_dbg  out  2      current FSM state, for observation only
//
// Handshake: start is a request qualified only in IDLE, which is exactly the
// condition busy==0. A start seen while busy is dropped, not queued. data is
// sampled only on the edge that accepts start. All outputs are registered
// (Moore), so start and data have no combinational path to any output.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

`ifdef SERIAL_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  // Both counters are loaded with (length - 1). Each FSM state exits on the
  // edge at which its counter reads zero, so the counters never wrap.
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [FRAME-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [FRAME-1:0] frame_load;

`ifdef SERIAL_PARITY_EN
  assign frame_load = {data, ^data};
`else
  assign frame_load = data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          shreg_d = frame_load;
          cnt_d   = CNT_LOAD;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          shreg_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = GAP_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          shreg_d = {shreg_q[FRAME-2:0], 1'b0};
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        gcnt_d  = '0;
      end
    endcase

    // The outputs are decoded from the next state, so the registered
    // outputs line up with the state register in the same cycle.
    case (state_d)
      S_SHIFT: begin
        x_d     = shreg_d[FRAME-1];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign x         = x_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx
//   Directed bench for serial_pattern_tx with WIDTH=8 and GAP=2.
//   Cycle numbering: "cycle n" is the interval just after active edge n-1.
//   A start that is accepted at edge 0 therefore puts its first bit in
//   cycle 1. Each frame occupies FB bit cycles, then 2 gap cycles, then
//   1 done cycle, then 1 idle cycle, for a period of P = FB + 4 cycles.
module tb_serial_pattern_tx;

`ifdef SERIAL_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif
  localparam int P = FB + 4;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       x, valid, busy, done;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .GAP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .x         (x),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ex, input logic ev,
                            input logic eb, input logic ed);
    check_eq({tag, " x"},     32'(x),     32'(ex));
    check_eq({tag, " valid"}, 32'(valid), 32'(ev));
    check_eq({tag, " busy"},  32'(busy),  32'(eb));
    check_eq({tag, " done"},  32'(done),  32'(ed));
  endtask

  // Expected outputs in local cycle l (1-based) of a frame carrying word w.
  task automatic check_frame_cycle(input string tag, input logic [7:0] w, input int l);
    logic ex, ev, eb, ed;
    ex = 1'b0; ev = 1'b0; eb = 1'b0; ed = 1'b0;
    if (l >= 1 && l <= FB) begin
      ex = (l <= 8) ? w[8-l] : ^w;
      ev = 1'b1;
      eb = 1'b1;
    end else if (l > FB && l <= FB + 2) begin
      eb = 1'b1;
    end else if (l == FB + 3) begin
      eb = 1'b1;
      ed = 1'b1;
    end
    check_outs($sformatf("%s c%0d", tag, l), ex, ev, eb, ed);
  endtask

  // Pulse start for one edge with word w, then check the whole period.
  task automatic send_and_check(input string tag, input logic [7:0] w);
    data  = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    data  = ~w;  // a mid-frame data change must have no effect
    for (int l = 1; l <= P; l++) begin
      if (l > 1) tick();
      check_frame_cycle(tag, w, l);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;

    // Test 1: reset, then idle with start low.
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Test 2: single frame 8'hB2 -> 1,0,1,1,0,0,1,0.
    send_and_check("b2", 8'hB2);

    // Test 6 pattern (parity 1 when enabled): 8'hB3.
    send_and_check("b3", 8'hB3);

    // Test 3: start held high, FF then 01, back to back.
    data  = 8'hFF;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 2 * P; c++) begin
      if (c > 1) tick();
      if (c <= P) check_frame_cycle("hold_ff", 8'hFF, c);
      else        check_frame_cycle("hold_01", 8'h01, c - P);
      if (c == 1)         data  = 8'h01;
      if (c == 2 * P - 1) start = 1'b0;
    end
    tick();
    check_outs("hold_end", 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 4: C3 frame, start with data 00 in cycle 4 must be ignored.
    data  = 8'hC3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int l = 1; l <= P + 4; l++) begin
      if (l > 1) tick();
      check_frame_cycle("c3", 8'hC3, l);
      if (l == 4) begin
        start = 1'b1;
        data  = 8'h00;
      end
      if (l == 5) start = 1'b0;
    end

    // Test 5: async reset in cycle 5 of an A5 frame.
    data  = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int l = 1; l <= 5; l++) begin
      if (l > 1) tick();
      check_frame_cycle("a5", 8'hA5, l);
    end
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("async_rst state", 32'(state_dbg), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < FB + 4; i++) begin
      tick();
      check_outs($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    send_and_check("5a", 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
